battleship_player_core: RTL

//  One player's board engine for N-cell Battleship. Latches the ship layout, validates own shots and tracks shot history.

---
 rtl/battleship_player_core.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/battleship_player_core.sv
// One player's Battleship board engine: ship load, shot validation and history, opponent-shot handling, turn FSM.
// Optional BS_STATS_EN macro adds saturating shots_fired / hits_taken counters (tied to zero otherwise).
module battleship_player_core #(
    parameter int unsigned CELLS      = 10,
    parameter int unsigned SHIPS      = 3,
    parameter bit          FIRST_MOVE = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [CELLS-1:0] ship_sw,
    input  logic             load_btn,
    input  logic             fire_btn,
    input  logic [CELLS-1:0] opp_attack,
    input  logic             opp_valid,
    input  logic             opp_alive,
    output logic [CELLS-1:0] my_attack,
    output logic             attack_valid,
    output logic             alive,
    output logic [CELLS-1:0] ship_leds,
    output logic             hit,
    output logic             err,
    output logic [2:0]       disp_sel,
    output logic [7:0]       shots_fired,
    output logic [7:0]       hits_taken
);

    typedef enum logic [2:0] {
        ST_LOAD     = 3'd0,
        ST_MY_TURN  = 3'd1,
        ST_OPP_TURN = 3'd2,
        ST_WIN      = 3'd3,
        ST_LOSE     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CELLS-1:0] ships_q, ships_d;
    logic [CELLS-1:0] history_q, history_d;
    logic [CELLS-1:0] my_attack_q, my_attack_d;
    logic             attack_valid_q, attack_valid_d;
    logic             hit_q, hit_d;
    logic             err_q, err_d;
    logic             load_dly_q, fire_dly_q;
    logic             load_edge, fire_edge;
    logic             shot_one_hot, shot_ok;

    assign load_edge    = load_btn & ~load_dly_q;
    assign fire_edge    = fire_btn & ~fire_dly_q;
    assign shot_one_hot = (ship_sw != '0) && ((ship_sw & (ship_sw - CELLS'(1))) == '0);
    assign shot_ok      = shot_one_hot && ((ship_sw & history_q) == '0);

    always_comb begin
        state_d        = state_q;
        ships_d        = ships_q;
        history_d      = history_q;
        my_attack_d    = my_attack_q;
        attack_valid_d = 1'b0;
        hit_d          = 1'b0;
        err_d          = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (load_edge) begin
                    if ($countones(ship_sw) == int'(SHIPS)) begin
                        ships_d = ship_sw;
                        state_d = FIRST_MOVE ? ST_MY_TURN : ST_OPP_TURN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_MY_TURN: begin
                // A defeated opponent ends the game before any pending shot is considered.
                if (!opp_alive) begin
                    state_d = ST_WIN;
                end else if (fire_edge) begin
                    if (shot_ok) begin
                        my_attack_d    = ship_sw;
                        history_d      = history_q | ship_sw;
                        attack_valid_d = 1'b1;
                        state_d        = ST_OPP_TURN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_OPP_TURN: begin
                if (opp_valid) begin
                    ships_d = ships_q & ~opp_attack;
                    hit_d   = |(ships_q & opp_attack);
                    state_d = (ships_d == '0) ? ST_LOSE : ST_MY_TURN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q        <= ST_LOAD;
            ships_q        <= '0;
            history_q      <= '0;
            my_attack_q    <= '0;
            attack_valid_q <= 1'b0;
            hit_q          <= 1'b0;
            err_q          <= 1'b0;
            load_dly_q     <= 1'b0;
            fire_dly_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ships_q        <= ships_d;
            history_q      <= history_d;
            my_attack_q    <= my_attack_d;
            attack_valid_q <= attack_valid_d;
            hit_q          <= hit_d;
            err_q          <= err_d;
            load_dly_q     <= load_btn;
            fire_dly_q     <= fire_btn;
        end
    end

    assign my_attack    = my_attack_q;
    assign attack_valid = attack_valid_q;
    assign ship_leds    = ships_q;
    assign hit          = hit_q;
    assign err          = err_q;
    assign disp_sel     = state_q;
    // The layout is still being entered in LOAD, so report alive there regardless of the register.
    assign alive        = (state_q == ST_LOAD) ? 1'b1 : |ships_q;

`ifdef BS_STATS_EN
    logic [7:0] shots_q, shots_d;
    logic [7:0] hits_q, hits_d;

    always_comb begin
        shots_d = shots_q;
        hits_d  = hits_q;
        if (attack_valid_d && (shots_q != 8'hFF)) shots_d = shots_q + 8'd1;
        if (hit_d && (hits_q != 8'hFF))           hits_d  = hits_q + 8'd1;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shots_q <= 8'd0;
            hits_q  <= 8'd0;
        end else begin
            shots_q <= shots_d;
            hits_q  <= hits_d;
        end
    end

    assign shots_fired = shots_q;
    assign hits_taken  = hits_q;
`else
    assign shots_fired = 8'd0;
    assign hits_taken  = 8'd0;
`endif

endmodule
